// File: rtl/load_store_unit_if.sv
// Core request/response and data-memory signals of the load/store unit.
// The slave modport is the unit's view; the master modport is the core plus memory side.
interface load_store_unit_if;
    logic       req_valid;
    logic       req_ready;
    logic       req_write;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic [1:0] req_len;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       wr_done;
    logic       busy;
    logic [7:0] mem_address;
    logic [7:0] mem_write_data;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] mem_read_data;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_len, rsp_ready, mem_read_data,
        output req_ready, rsp_valid, rsp_data, wr_done, busy, mem_address, mem_write_data,
               mem_read, mem_write
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_len, rsp_ready, mem_read_data,
        input  req_ready, rsp_valid, rsp_data, wr_done, busy, mem_address, mem_write_data,
               mem_read, mem_write
    );
endinterface

// File: rtl/load_store_unit.sv
// Byte load/store unit: fill-stores and burst loads of 1..4 bytes against a synchronous
// data memory with one cycle of read latency.
module load_store_unit (
    input logic              clk,
    input logic              rst,
    load_store_unit_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StWr, StRd, StRdWait, StRsp} state_e;

    state_e     state_q, state_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wdata_q, wdata_d;
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] rsp_data_q, rsp_data_d;
    logic       wr_done_q, wr_done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            addr_q     <= 8'h00;
            wdata_q    <= 8'h00;
            cnt_q      <= 2'd0;
            rsp_data_q <= 8'h00;
            wr_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rsp_data_q <= rsp_data_d;
            wr_done_q  <= wr_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rsp_data_d = rsp_data_q;
        wr_done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    addr_d  = bus.req_addr;
                    wdata_d = bus.req_wdata;
                    cnt_d   = bus.req_len;
                    state_d = bus.req_write ? StWr : StRd;
                end
            end
            StWr: begin
                if (cnt_q == 2'd0) begin
                    state_d   = StIdle;
                    wr_done_d = 1'b1;
                end else begin
                    addr_d = addr_q + 8'd1;
                    cnt_d  = cnt_q - 2'd1;
                end
            end
            StRd: state_d = StRdWait;
            StRdWait: begin
                rsp_data_d = bus.mem_read_data;
                state_d    = StRsp;
            end
            StRsp: begin
                if (bus.rsp_ready) begin
                    if (cnt_q == 2'd0) begin
                        state_d = StIdle;
                    end else begin
                        addr_d  = addr_q + 8'd1;
                        cnt_d   = cnt_q - 2'd1;
                        state_d = StRd;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Only req_ready looks at rst directly; everything else follows the reset registers.
    assign bus.req_ready      = (state_q == StIdle) && !rst;
    assign bus.rsp_valid      = (state_q == StRsp);
    assign bus.rsp_data       = rsp_data_q;
    assign bus.wr_done        = wr_done_q;
    assign bus.busy           = (state_q != StIdle);
    assign bus.mem_address    = addr_q;
    assign bus.mem_write_data = wdata_q;
    assign bus.mem_read       = (state_q == StRd);
    assign bus.mem_write      = (state_q == StWr);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural synchronous data memory.
module tb_load_store_unit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_clr = 1'b1;
    int   compared = 0;
    int   mism = 0;

    load_store_unit_if bus ();

    load_store_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic [7:0] rd_q;

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (bus.mem_write) begin
            mem[bus.mem_address] <= bus.mem_write_data;
        end
        if (bus.mem_read) rd_q <= mem[bus.mem_address];
    end

    assign bus.mem_read_data = rd_q;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mism++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge; mem_read and mem_write must never coincide.
    task automatic step();
        @(negedge clk);
        check("rd_wr_excl", {7'd0, bus.mem_read & bus.mem_write}, 8'h00);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, {7'd0, bus.req_ready}, 8'h00);
        check({tag, "_rsp_valid"}, {7'd0, bus.rsp_valid}, 8'h00);
        check({tag, "_rsp_data"},  bus.rsp_data, 8'h00);
        check({tag, "_wr_done"},   {7'd0, bus.wr_done}, 8'h00);
        check({tag, "_busy"},      {7'd0, bus.busy}, 8'h00);
        check({tag, "_mem_addr"},  bus.mem_address, 8'h00);
        check({tag, "_mem_wdata"}, bus.mem_write_data, 8'h00);
        check({tag, "_mem_read"},  {7'd0, bus.mem_read}, 8'h00);
        check({tag, "_mem_write"}, {7'd0, bus.mem_write}, 8'h00);
    endtask

    task automatic request(input logic wr, input logic [7:0] a, input logic [7:0] d,
                           input logic [1:0] len);
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = a;
        bus.req_wdata = d;
        bus.req_len   = len;
    endtask

    logic [7:0] burst_addr [4];

    initial begin
        burst_addr[0] = 8'hFE; burst_addr[1] = 8'hFF;
        burst_addr[2] = 8'h00; burst_addr[3] = 8'h01;
        bus.rsp_ready = 1'b0;
        request(1'b0, 8'h33, 8'h44, 2'd1);

        // Reset: everything low, req_ready held off even with req_valid high
        step();
        check_all_zero("reset");
        bus.req_valid = 1'b0;
        mem_clr = 1'b0;
        rst = 1'b0;
        #1 check("ready_after_rst", {7'd0, bus.req_ready}, 8'h01);

        // Single store 0x0E -> 0x0C
        step();
        request(1'b1, 8'h0C, 8'h0E, 2'd0);
        step();
        bus.req_valid = 1'b0;
        check("st1_mem_write", {7'd0, bus.mem_write}, 8'h01);
        check("st1_addr", bus.mem_address, 8'h0C);
        check("st1_wdata", bus.mem_write_data, 8'h0E);
        check("st1_busy", {7'd0, bus.busy}, 8'h01);
        check("st1_req_ready", {7'd0, bus.req_ready}, 8'h00);
        step();
        check("st1_wr_done", {7'd0, bus.wr_done}, 8'h01);
        check("st1_write_off", {7'd0, bus.mem_write}, 8'h00);
        check("st1_idle", {7'd0, bus.busy}, 8'h00);
        step();
        check("st1_wr_done_once", {7'd0, bus.wr_done}, 8'h00);
        check("st1_mem", mem[8'h0C], 8'h0E);

        // Single load from 0x0C
        request(1'b0, 8'h0C, 8'h00, 2'd0);
        step();
        bus.req_valid = 1'b0;
        check("ld1_mem_read", {7'd0, bus.mem_read}, 8'h01);
        check("ld1_addr", bus.mem_address, 8'h0C);
        check("ld1_rsp_early1", {7'd0, bus.rsp_valid}, 8'h00);
        step();
        check("ld1_wait_read", {7'd0, bus.mem_read}, 8'h00);
        check("ld1_rsp_early2", {7'd0, bus.rsp_valid}, 8'h00);
        step();
        check("ld1_rsp_valid", {7'd0, bus.rsp_valid}, 8'h01);
        check("ld1_rsp_data", bus.rsp_data, 8'h0E);
        bus.rsp_ready = 1'b1;
        step();
        check("ld1_idle", {7'd0, bus.busy}, 8'h00);
        check("ld1_rsp_gone", {7'd0, bus.rsp_valid}, 8'h00);
        // rsp_ready with nothing pending is harmless
        step();
        check("rsp_ready_idle", {7'd0, bus.busy}, 8'h00);
        bus.rsp_ready = 1'b0;

        // Burst fill across the 0xFF -> 0x00 wrap
        request(1'b1, 8'hFE, 8'h1E, 2'd3);
        for (int b = 0; b < 4; b++) begin
            step();
            bus.req_valid = 1'b0;
            check("fill_write", {7'd0, bus.mem_write}, 8'h01);
            check("fill_addr", bus.mem_address, burst_addr[b]);
            check("fill_no_done", {7'd0, bus.wr_done}, 8'h00);
        end
        step();
        check("fill_wr_done", {7'd0, bus.wr_done}, 8'h01);
        check("fill_idle", {7'd0, bus.busy}, 8'h00);
        for (int b = 0; b < 4; b++) check("fill_mem", mem[burst_addr[b]], 8'h1E);
        check("fill_mem_below", mem[8'hFD], 8'h00);
        check("fill_mem_above", mem[8'h02], 8'h00);

        // Four-byte load over the same wrapped range
        request(1'b0, 8'hFE, 8'h00, 2'd3);
        step();
        bus.req_valid = 1'b0;
        for (int b = 0; b < 4; b++) begin
            check("bld_mem_read", {7'd0, bus.mem_read}, 8'h01);
            check("bld_addr", bus.mem_address, burst_addr[b]);
            step();
            check("bld_wait", {7'd0, bus.rsp_valid}, 8'h00);
            step();
            check("bld_rsp_valid", {7'd0, bus.rsp_valid}, 8'h01);
            check("bld_rsp_data", bus.rsp_data, 8'h1E);
            bus.rsp_ready = 1'b1;
            step();
            bus.rsp_ready = 1'b0;
        end
        check("bld_idle", {7'd0, bus.busy}, 8'h00);

        // Backpressure: distinct bytes at 0x40/0x41, hold rsp_ready low for 5 cycles
        request(1'b1, 8'h40, 8'hA5, 2'd0);
        step();
        bus.req_valid = 1'b0;
        step();
        request(1'b1, 8'h41, 8'h5A, 2'd0);
        step();
        bus.req_valid = 1'b0;
        step();
        request(1'b0, 8'h40, 8'h00, 2'd1);
        step();
        bus.req_valid = 1'b0;
        step();
        step();
        for (int c = 0; c < 5; c++) begin
            if (c % 2 == 0) request(1'b1, 8'h99, 8'hCC, 2'd0);
            else bus.req_valid = 1'b0;
            step();
            check("bp_rsp_valid", {7'd0, bus.rsp_valid}, 8'h01);
            check("bp_rsp_data", bus.rsp_data, 8'hA5);
            check("bp_no_read", {7'd0, bus.mem_read}, 8'h00);
            check("bp_no_write", {7'd0, bus.mem_write}, 8'h00);
            check("bp_not_ready", {7'd0, bus.req_ready}, 8'h00);
        end
        bus.req_valid = 1'b0;
        check("bp_ignored_store", mem[8'h99], 8'h00);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("bp_2nd_read", {7'd0, bus.mem_read}, 8'h01);
        check("bp_2nd_addr", bus.mem_address, 8'h41);
        step();
        step();
        check("bp_2nd_data", bus.rsp_data, 8'h5A);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("bp_idle", {7'd0, bus.busy}, 8'h00);

        // Reset during the second cycle of a 4-byte store
        request(1'b1, 8'h50, 8'hAA, 2'd3);
        step();
        bus.req_valid = 1'b0;
        step();
        check("rm_second_addr", bus.mem_address, 8'h51);
        #2 rst = 1'b1;
        #1 check_all_zero("rm");
        step();
        rst = 1'b0;
        step();
        check("rm_no_wr_done", {7'd0, bus.wr_done}, 8'h00);
        check("rm_still_idle", {7'd0, bus.busy}, 8'h00);
        check("rm_mem_first", mem[8'h50], 8'hAA);
        check("rm_mem_third", mem[8'h52], 8'h00);
        check("rm_mem_fourth", mem[8'h53], 8'h00);
        request(1'b0, 8'h50, 8'h00, 2'd0);
        step();
        bus.req_valid = 1'b0;
        check("rm_accept", {7'd0, bus.mem_read}, 8'h01);
        check("rm_accept_addr", bus.mem_address, 8'h50);
        step();
        step();
        check("rm_load_data", bus.rsp_data, 8'hAA);
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        check("rm_load_idle", {7'd0, bus.busy}, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
